mac_accum: RTL and testbench

//  Downstream consumer of the signed 4x4 multiplier stage: accumulates a stream
//  of signed products into a running sum, one frame at a time, and hands the

---
 rtl/mac_accum.sv | 111 +++++++++++
 tb/tb_mac_accum.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum.sv
// Frame accumulator for signed products with a valid/ready result handshake.
// Optional MAC_ACCUM_SAT_EN: saturate on overflow instead of wrapping.
module mac_accum #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16,
  localparam int CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic        [CW-1:0]     out_count,
  output logic                     out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                   state_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  prod_ext, sum_raw;
  logic        [CW-1:0]     cnt_q, cnt_d;
  logic                     ovf_q, add_ovf;
  logic                     out_valid_q, in_ready_q;
  logic                     beat, closing;

`ifdef MAC_ACCUM_SAT_EN
  // Clamp toward the side the accumulator was already on; a single add can
  // only overflow in the direction of the current sign.
  function automatic logic signed [ACC_W-1:0] sat_fix(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [ACC_W-1:0] raw,
    input logic                    ovf
  );
    if (!ovf) return raw;
    return acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction
`endif

  always_comb begin
    prod_ext = ACC_W'(in_prod);
    sum_raw  = acc_q + prod_ext;
    add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef MAC_ACCUM_SAT_EN
    acc_d    = sat_fix(acc_q, sum_raw, add_ovf);
`else
    acc_d    = sum_raw;
`endif
    cnt_d    = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
    beat     = in_valid && in_ready_q;
    closing  = in_last || (cnt_d == CW'(MAX_TERMS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (beat) begin
            cnt_q <= cnt_d;
            if (state_q == IDLE) begin
              acc_q <= prod_ext;
              ovf_q <= 1'b0;
            end else begin
              acc_q <= acc_d;
              ovf_q <= ovf_q | add_ovf;
            end
            if (closing) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: directed frames plus random traffic against a frame-level model.
// Drives a default-width instance and an ACC_W=10 instance from the same stimulus.
module tb_mac_accum;
  localparam int MT = 16;
  localparam int CW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_prod = '0;
  logic              in_last = 1'b0;
  logic              out_ready;
  logic              ordy_val = 1'b0, rmode = 1'b0, rnd_bit = 1'b0;

  logic              in_ready, out_valid, out_ovf;
  logic signed [11:0] out_sum;
  logic [CW-1:0]     out_count;
  logic              in_ready10, out_valid10, out_ovf10;
  logic signed [9:0] out_sum10;
  logic [CW-1:0]     out_count10;

  int errs = 0, checks = 0;

  // model state
  int m_acc12, m_acc10, m_cnt, mp, ms;
  bit m_ovf12, m_ovf10, m_hold, m_open;

  mac_accum #(.PROD_W(8), .ACC_W(12), .MAX_TERMS(MT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_ovf(out_ovf));

  mac_accum #(.PROD_W(8), .ACC_W(10), .MAX_TERMS(MT)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid10),
    .out_ready(out_ready), .out_sum(out_sum10), .out_count(out_count10),
    .out_ovf(out_ovf10));

  always #5 clk = ~clk;

  assign out_ready = rmode ? rnd_bit : ordy_val;
  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 2) != 0);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input int s, input int w);
    return (s <= (1 << (w - 1)) - 1) && (s >= -(1 << (w - 1)));
  endfunction

  function automatic int fit(input int s, input int w);
    int mx, mn;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    if (in_range(s, w)) return s;
`ifdef MAC_ACCUM_SAT_EN
    return (s > mx) ? mx : mn;
`else
    return ((s - mn + (1 << w)) % (1 << w)) + mn;
`endif
  endfunction

  // Frame-level model: inputs and outputs are stable at the falling edge,
  // so this predicts what the next rising edge does.
  always @(negedge clk) begin
    if (rst) begin
      m_hold = 0; m_open = 0; m_cnt = 0;
      m_acc12 = 0; m_acc10 = 0; m_ovf12 = 0; m_ovf10 = 0;
    end else begin
      check("in_ready", in_ready, m_hold ? 0 : 1);
      check("in_ready10", in_ready10, m_hold ? 0 : 1);
      check("out_valid", out_valid, m_hold);
      check("out_valid10", out_valid10, m_hold);
      if (m_hold) begin
        check("out_sum", out_sum, m_acc12);
        check("out_sum10", out_sum10, m_acc10);
        check("out_count", out_count, m_cnt);
        check("out_count10", out_count10, m_cnt);
        check("out_ovf", out_ovf, m_ovf12);
        check("out_ovf10", out_ovf10, m_ovf10);
        if (out_ready) m_hold = 0;
      end else if (in_valid) begin
        mp = in_prod;
        if (!m_open) begin
          m_acc12 = mp; m_acc10 = mp; m_cnt = 1;
          m_ovf12 = 0; m_ovf10 = 0; m_open = 1;
        end else begin
          ms = m_acc12 + mp;
          if (!in_range(ms, 12)) m_ovf12 = 1;
          m_acc12 = fit(ms, 12);
          ms = m_acc10 + mp;
          if (!in_range(ms, 10)) m_ovf10 = 1;
          m_acc10 = fit(ms, 10);
          m_cnt++;
        end
        if (in_last || m_cnt == MT) begin
          m_hold = 1; m_open = 0;
        end
      end
    end
  end

  task automatic send(input int p, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1; in_prod = 8'(p); in_last = last;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    int exp10;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);

    // frame 3,-5,12
    send(3, 0); send(-5, 0); send(12, 1);
    check("t1_valid", out_valid, 1);
    check("t1_sum", out_sum, 10);
    check("t1_count", out_count, 3);
    check("t1_ovf", out_ovf, 0);
    ordy_val = 1'b1;
    @(posedge clk); #1;
    check("t1_release", out_valid, 0);
    ordy_val = 1'b0;

    // single beat -64
    send(-64, 1);
    check("t2_sum", out_sum, -64);
    check("t2_count", out_count, 1);
    ordy_val = 1'b1;
    @(posedge clk); #1;
    check("t2_valid_drop", out_valid, 0);
    check("t2_in_ready", in_ready, 1);
    ordy_val = 1'b0;

    // backpressure with input waiting
    send(1, 1);
    in_valid = 1'b1; in_prod = 8'sd99; in_last = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("t3_in_ready", in_ready, 0);
      check("t3_sum", out_sum, 1);
      check("t3_count", out_count, 1);
    end
    ordy_val = 1'b1;
    @(posedge clk); #1;
    check("t3_idle_valid", out_valid, 0);
    check("t3_idle_ready", in_ready, 1);
    ordy_val = 1'b0;
    @(posedge clk); #1;
    check("t3_next_valid", out_valid, 1);
    check("t3_next_sum", out_sum, 99);
    in_valid = 1'b0; in_last = 1'b0;
    ordy_val = 1'b1;
    @(posedge clk); #1;
    ordy_val = 1'b0;

    // force-close at 16 terms
    repeat (16) send(64, 0);
    check("t4_valid", out_valid, 1);
    check("t4_sum", out_sum, 1024);
    check("t4_count", out_count, 16);
    check("t4_ovf", out_ovf, 0);
`ifdef MAC_ACCUM_SAT_EN
    exp10 = 511;
`else
    exp10 = 0;
`endif
    check("t5_sum10", out_sum10, exp10);
    check("t5_ovf10", out_ovf10, 1);
    ordy_val = 1'b1;
    send(5, 1);
    check("t4_next_sum", out_sum, 5);
    check("t4_next_count", out_count, 1);
    @(posedge clk); #1;
    ordy_val = 1'b0;

    // asynchronous reset mid-frame
    send(3, 0); send(4, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_sum", out_sum, 0);
    check("t6_count", out_count, 0);
    check("t6_ovf", out_ovf, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    send(7, 0); send(1, 1);
    check("t6_sum_after", out_sum, 8);
    check("t6_count_after", out_count, 2);
    ordy_val = 1'b1;
    @(posedge clk); #1;

    // random traffic
    rmode = 1'b1;
    repeat (3000) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       in_prod = 8'sd127;
        1:       in_prod = -8'sd128;
        default: in_prod = 8'($urandom);
      endcase
      in_last = ($urandom_range(0, 5) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    rmode = 1'b0; ordy_val = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
